// File: rtl/param_stack.sv
// Parametrised LIFO stack with registered top/second view, sticky error flags,
// one-cycle peek port and synchronous clear. Flags track the post-edge count.
module param_stack #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 32,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  input  logic              err_clr,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] top,
  output logic [DATA_W-1:0] second,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_hit
);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [CNT_W-1:0]  cnt_nxt;
  logic [DATA_W-1:0] top_nxt;
  logic [DATA_W-1:0] second_nxt;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic              ovf_evt;
  logic              udf_evt;
  logic [IDX_W-1:0]  top_addr;
  logic [IDX_W-1:0]  third_addr;
  logic [IDX_W-1:0]  peek_addr;
  logic              peek_ok;

  // Indices are taken modulo DEPTH; they are only used when the slot is valid.
  assign top_addr   = count[IDX_W-1:0] - IDX_W'(1);
  assign third_addr = count[IDX_W-1:0] - IDX_W'(3);
  assign peek_addr  = count[IDX_W-1:0] - IDX_W'(1) - rd_idx;
  assign peek_ok    = ({1'b0, rd_idx} < count);

  always_comb begin
    cnt_nxt    = count;
    top_nxt    = top;
    second_nxt = second;
    mem_we     = 1'b0;
    mem_waddr  = count[IDX_W-1:0];
    ovf_evt    = 1'b0;
    udf_evt    = 1'b0;
    if (clear) begin
      cnt_nxt    = '0;
      top_nxt    = '0;
      second_nxt = '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (full) begin
            ovf_evt = 1'b1;
          end else begin
            mem_we     = 1'b1;
            mem_waddr  = count[IDX_W-1:0];
            cnt_nxt    = count + CNT_W'(1);
            top_nxt    = data_in;
            second_nxt = top;
          end
        end
        2'b01: begin
          if (empty) begin
            udf_evt = 1'b1;
          end else begin
            cnt_nxt    = count - CNT_W'(1);
            top_nxt    = second;
            second_nxt = (count >= CNT_W'(3)) ? mem[third_addr] : '0;
          end
        end
        2'b11: begin
          // Replace-top: count and second are untouched, legal even when full.
          if (empty) begin
            udf_evt = 1'b1;
          end else begin
            mem_we    = 1'b1;
            mem_waddr = top_addr;
            top_nxt   = data_in;
          end
        end
        default: ;
      endcase
    end
  end

  // Stage boundary: storage array, no reset.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) mem[mem_waddr] <= data_in;
  end

  // Stage boundary: registered status, view and peek outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count     <= '0;
      top       <= '0;
      second    <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      rd_data   <= '0;
      rd_hit    <= 1'b0;
    end else begin
      count     <= cnt_nxt;
      top       <= top_nxt;
      second    <= second_nxt;
      empty     <= (cnt_nxt == '0);
      full      <= (cnt_nxt == CNT_W'(DEPTH));
      overflow  <= ovf_evt | (overflow & ~err_clr);
      underflow <= udf_evt | (underflow & ~err_clr);
      rd_data   <= peek_ok ? mem[peek_addr] : '0;
      rd_hit    <= peek_ok;
    end
  end

endmodule

// File: tb/tb_param_stack.sv
// Scoreboard bench for param_stack: a queue-based stack model predicts every
// cycle's outputs, and a monitor compares them one cycle after issue.
module tb_param_stack;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int IDX_W  = $clog2(DEPTH);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n = 1'b0, clear = 1'b0, push = 1'b0, pop = 1'b0, err_clr = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic [IDX_W-1:0]  rd_idx = '0;
  logic [DATA_W-1:0] top, second, rd_data;
  logic [CNT_W-1:0]  count;
  logic              empty, full, overflow, underflow, rd_hit;

  param_stack #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .push(push), .pop(pop),
    .data_in(data_in), .err_clr(err_clr), .rd_idx(rd_idx),
    .top(top), .second(second), .count(count), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow), .rd_data(rd_data), .rd_hit(rd_hit)
  );

  typedef struct {
    int count, top, second, empty, full, ovf, udf, rd_data, rd_hit;
  } exp_t;

  exp_t exp_q[$];
  int   stk[$];
  bit   m_ovf = 0, m_udf = 0;
  int   checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input int expv);
    checks++;
    if (act !== 32'(expv)) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Issue one cycle of stimulus and push the model's prediction.
  task automatic drive(input bit r_n, input bit cl, input bit pu, input bit po,
                       input int din, input bit ec, input int idx);
    exp_t e;
    int   n;
    @(negedge clk);
    rst_n = r_n; clear = cl; push = pu; pop = po; err_clr = ec;
    data_in = DATA_W'(din); rd_idx = IDX_W'(idx);
    din = din & ((1 << DATA_W) - 1);
    n = stk.size();
    e.rd_hit  = (idx < n) ? 1 : 0;
    e.rd_data = (idx < n) ? stk[n-1-idx] : 0;
    if (!r_n) begin
      stk.delete(); m_ovf = 0; m_udf = 0; e.rd_hit = 0; e.rd_data = 0;
    end else begin
      if (ec) begin m_ovf = 0; m_udf = 0; end
      if (cl) stk.delete();
      else if (pu && !po) begin
        if (n == DEPTH) m_ovf = 1; else stk.push_back(din);
      end else if (po && !pu) begin
        if (n == 0) m_udf = 1; else void'(stk.pop_back());
      end else if (pu && po) begin
        if (n == 0) m_udf = 1; else stk[n-1] = din;
      end
    end
    n = stk.size();
    e.count  = n;
    e.top    = (n > 0) ? stk[n-1] : 0;
    e.second = (n > 1) ? stk[n-2] : 0;
    e.empty  = (n == 0);
    e.full   = (n == DEPTH);
    e.ovf    = m_ovf;
    e.udf    = m_udf;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int idx);
    drive(1, 0, 0, 0, 0, 0, idx);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("count", 32'(count), e.count);
        chk("top", 32'(top), e.top);
        chk("second", 32'(second), e.second);
        chk("empty", 32'(empty), e.empty);
        chk("full", 32'(full), e.full);
        chk("overflow", 32'(overflow), e.ovf);
        chk("underflow", 32'(underflow), e.udf);
        chk("rd_data", 32'(rd_data), e.rd_data);
        chk("rd_hit", 32'(rd_hit), e.rd_hit);
      end
    end
  end

  initial begin : stimulus
    bit r, c, ec;
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 8'h99, 0, 0);
    // Basic push/pop ordering.
    drive(1, 0, 1, 0, 8'h11, 0, 0);
    drive(1, 0, 1, 0, 8'h22, 0, 0);
    drive(1, 0, 1, 0, 8'h33, 0, 0);
    drive(1, 0, 0, 1, 0, 0, 0);
    drive(1, 0, 0, 1, 0, 0, 0);
    drive(1, 0, 0, 1, 0, 0, 0);
    // Underflow stickiness, error set wins over err_clr.
    drive(1, 0, 0, 1, 0, 0, 0);
    drive(1, 0, 0, 1, 0, 1, 0);
    drive(1, 0, 1, 1, 8'h77, 0, 0);
    drive(1, 0, 0, 0, 0, 1, 0);
    // Replace-top, then fill and replace while full.
    drive(1, 0, 1, 0, 8'hA0, 0, 0);
    drive(1, 0, 1, 0, 8'hB0, 0, 0);
    drive(1, 0, 1, 1, 8'hC5, 0, 0);
    drive(1, 0, 1, 0, 8'h03, 0, 0);
    drive(1, 0, 1, 0, 8'h04, 0, 0);
    drive(1, 0, 1, 1, 8'hEE, 0, 0);
    drive(1, 0, 1, 0, 8'h55, 0, 0);
    drive(1, 0, 0, 0, 0, 1, 0);
    // Five pushes into DEPTH=4, then peek every slot.
    drive(1, 1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) drive(1, 0, 1, 0, i, 0, 0);
    for (int i = 0; i < DEPTH; i++) idle(i);
    idle(0);
    drive(1, 0, 0, 1, 0, 0, 3);
    drive(1, 0, 0, 1, 0, 0, 3);
    idle(3);
    idle(1);
    // Clear beats a push and keeps the sticky flag; reset beats a push.
    drive(1, 0, 1, 0, 8'h61, 0, 0);
    drive(1, 0, 1, 0, 8'h62, 0, 0);
    drive(1, 0, 1, 0, 8'h63, 0, 0);
    drive(1, 1, 1, 0, 8'h64, 0, 0);
    drive(1, 0, 1, 0, 8'h65, 0, 0);
    drive(0, 0, 1, 0, 8'h66, 0, 0);
    idle(0);
    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      r  = ($urandom_range(0, 99) >= 1);
      c  = ($urandom_range(0, 99) < 4);
      ec = c ? 1'b0 : ($urandom_range(0, 99) < 10);
      drive(r, c, $urandom_range(0, 1), $urandom_range(0, 1), $urandom, ec,
            $urandom_range(0, DEPTH - 1));
    end
    idle(0);
    @(posedge clk);
    #3;
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL timeout: simulation did not complete, checks %0d", checks);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/param_stack.md
# param_stack

Parametrised LIFO stack for the processor module, the next generation of the fixed 8-bit × 32 stack used for subroutine return addresses and operand storage. Width and depth are configurable. Simultaneous push+pop performs a replace-top. Status flags reflect the post-operation state with no cycle of lag. The block adds sticky overflow/underflow error flags, a registered top/second-of-stack view, a random-access peek port, and a synchronous clear.

## Interface
- DATA_W, 8: element width in bits (≥1).
- DEPTH, 32: number of entries; power of two, ≥4.
- CNT_W, $clog2(DEPTH+1): width of count (derived, not overridden).
- IDX_W, $clog2(DEPTH): width of peek index (derived).

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- clear  in  1  flush stack (count→0); highest priority after reset.
- push  in  1  push data_in.
- pop  in  1  pop top element.
- data_in  in  DATA_W  value to push / replace.
- err_clr  in  1  clear sticky overflow/underflow.
- rd_idx  in  IDX_W  peek offset from top (0 = top).
- top  out  DATA_W  current top element, 0 when empty (registered).
- second  out  DATA_W  element below top, 0 when count<2 (registered).
- count  out  CNT_W  number of valid entries (registered).
- empty  out  1  count==0 (registered).
- full  out  1  count==DEPTH (registered).
- overflow  out  1  sticky: push attempted while full.
- underflow  out  1  sticky: pop attempted while empty.
- rd_data  out  DATA_W  peek result, 1-cycle latency.
- rd_hit  out  1  peek index was valid (rd_idx < count).

## Operation
- Storage: mem[0..DEPTH-1] with mem[count-1] as the top. mem is not reset. Next state is decoded from pre-edge count.
- Priority per edge: !rst_n > clear > {push,pop} decode.
- clear: count←0, top←0, second←0. Sticky flags unchanged. push/pop ignored that cycle.
- push only, !full: mem[count]←data_in, count+1, top←data_in, second←old top.
- push only, full: no state change, overflow←1.
- pop only, !empty: count−1, top←old second, second←mem[count−3] if count≥3 else 0.
- pop only, empty: no change, underflow←1.
- push&pop, !empty: replace top. mem[count−1]←data_in, top←data_in, count and second unchanged. Legal when full; no overflow.
- push&pop, empty: no change, underflow←1.
- err_clr clears both sticky flags. An error event in the same cycle wins (flag stays 1).
- Peek: rd_data←mem[count−1−rd_idx] and rd_hit←1 if rd_idx<count, else rd_data←0 and rd_hit←0. Uses pre-edge count and contents; a push/pop on the same edge is not reflected.
- Arithmetic: count is CNT_W bits and never wraps. Saturation is enforced by the full/empty guards, not by modulo.

## Timing
- Reset values: count=0, empty=1, full=0, top=0, second=0, overflow=0, underflow=0, rd_data=0, rd_hit=0.
- All outputs are registered. Effects of an operation sampled at edge N are visible after edge N: top, second, count, empty and full are all mutually consistent in the same cycle.
- empty and full are computed from next-count, never from current count, so there is no one-cycle flag lag.
- Back-to-back operations are allowed every cycle; throughput is 1 op/cycle.
- rd_data/rd_hit latency is 1 cycle from rd_idx.
- rst_n low mid-sequence: state returns to reset values at that edge, regardless of push/pop/clear.

## Test plan
- Reset, then push 0x11,0x22,0x33 on consecutive cycles → after 3rd edge count=3, top=0x33, second=0x22, empty=0. Pop twice → top=0x11, second=0, count=1.
- DATA_W=8, DEPTH=4: push 5 values → full=1 after 4th edge; 5th push leaves top unchanged and sets overflow=1. err_clr → overflow=0.
- Pop on empty stack → underflow=1, count=0, top=0. Assert err_clr together with another empty pop → underflow stays 1.
- Stack [0xA0,0xB0] (top 0xB0), push&pop with data_in=0xC5 → top=0xC5, second=0xA0, count=2. Repeat while full (DEPTH=4) → no overflow.
- Stack [1,2,3,4] (top 4), rd_idx=0..3 → rd_data 4,3,2,1 with rd_hit=1 one cycle later. rd_idx=3 with count=2 → rd_data=0, rd_hit=0.
- Mid-stream: clear with push=1 → count=0, empty=1, top=0, sticky flags retained. rst_n=0 with pending push → all outputs at reset values.
